mup_link: RTL

- RS-485 half-duplex link engine between the pult transfer FSM and one addressed panel module (MUP).
- On `start`, sends the LED word to module `n_mup`, then waits for and parses that module's reply.
- Returns buttons, 24-bit analog data and status flags; ends with `busy` falling.
- Sits directly downstream of the pult I/O sequencer. That sequencer drives `start`/`n_mup`/`led` and samples the results when `busy` falls.

---
 rtl/mup_link_pkg.sv | 37 +++
 rtl/mup_link_if.sv | 35 +++
 rtl/mup_uart_rx.sv | 122 ++++++++++++
 rtl/mup_link.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mup_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mup_link_pkg
//  Description : Shared constants, FSM state types and checksum helper for
//                the mup_link RS-485 link engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mup_link_pkg;

  // Upper five bits of every address byte on the wire.
  localparam logic [4:0] ADDR_TAG = 5'b10100;
  localparam int TX_BYTES = 4;
  localparam int RX_BYTES = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TX    = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RX    = 3'd4,
    ST_DONE  = 3'd5
  } link_state_e;

  typedef enum logic [1:0] {
    RX_HUNT  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Running packet checksum: plain byte XOR.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mup_link_if.sv
`default_nettype none
// ============================================================================
//  Module      : mup_link_if
//  Description : Sequencer-side and line-side signals of the MUP link.
//                master = sequencer / line model, slave = mup_link.
//  Ports       : clk_en, data_i, start, n_mup[2:0], led[15:0]   (to link)
//                data_o, dir_485, busy, error, answer,
//                but[15:0], an_data[23:0]                        (from link)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mup_link_if;
  logic        clk_en;
  logic        data_i;
  logic        data_o;
  logic        dir_485;
  logic        start;
  logic [2:0]  n_mup;
  logic [15:0] led;
  logic        busy;
  logic        error;
  logic        answer;
  logic [15:0] but;
  logic [23:0] an_data;

  modport master (
    output clk_en, data_i, start, n_mup, led,
    input  data_o, dir_485, busy, error, answer, but, an_data
  );

  modport slave (
    input  clk_en, data_i, start, n_mup, led,
    output data_o, dir_485, busy, error, answer, but, an_data
  );
endinterface
`default_nettype wire

// File: rtl/mup_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mup_uart_rx
//  Description : 8N1 byte receiver: 2-flop synchronizer, start-bit
//                validation at mid-bit, mid-bit data/stop sampling.
//  Ports       : clk, rst_n      clock, synchronous active-low reset
//                clk_en_i        clock enable (state moves only when 1)
//                en_i            hunt for start bits only while 1
//                rxd_i           asynchronous serial line
//                byte_o          last received byte
//                byte_vld_o      one enabled tick per received byte
//                frame_err_o     stop bit of byte_o was 0
//                busy_o          a byte is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module mup_uart_rx import mup_link_pkg::*; #(
  parameter int BIT_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en_i,
  input  logic       en_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam logic [15:0] BD_M1   = 16'(BIT_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BIT_DIV / 2 - 1);

  rx_state_e   st_q, st_d;
  logic        s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        vld_q, vld_d, fe_q, fe_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= RX_HUNT;
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      vld_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else if (clk_en_i) begin
      st_q   <= st_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      fe_q   <= fe_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    s1_d   = rxd_i;
    s2_d   = s1_q;
    prev_d = s2_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    fe_d   = fe_q;
    case (st_q)
      RX_HUNT: begin
        if (en_i && prev_q && !s2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          // Line back high at mid start bit: treat the edge as a glitch.
          st_d  = s2_q ? RX_HUNT : RX_DATA;
          cnt_d = '0;
          bit_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BD_M1) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BD_M1) begin
          vld_d = 1'b1;
          fe_d  = !s2_q;
          st_d  = RX_HUNT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: st_d = RX_HUNT;
    endcase
    if (!en_i) st_d = RX_HUNT;
  end

  assign byte_o      = sh_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = fe_q;
  assign busy_o      = (st_q != RX_HUNT);

endmodule
`default_nettype wire

// File: rtl/mup_link.sv
`default_nettype none
// ============================================================================
//  Module      : mup_link
//  Description : RS-485 half-duplex link engine. On start, sends
//                {ADDR, led lo, led hi, CHK} to module n_mup, then receives
//                the 7-byte reply {ADDR, but lo/hi, an 0/1/2, CHK}.
//  Ports       : clk, rst_n   clock, synchronous active-low reset
//                bus          mup_link_if.slave (handshake, line, results)
//  Revision    : 1.0 - initial release
// ============================================================================
module mup_link import mup_link_pkg::*; #(
  parameter int BIT_DIV      = 16,
  parameter int TIMEOUT_BITS = 40,
  parameter int GUARD_BITS   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mup_link_if.slave bus
);

  localparam int          TX_BITS  = TX_BYTES * 10;
  localparam logic [15:0] BD_M1    = 16'(BIT_DIV - 1);
  localparam logic [15:0] GUARD_M1 = 16'(GUARD_BITS * BIT_DIV - 1);
  localparam logic [15:0] TO_M1    = 16'(TIMEOUT_BITS * BIT_DIV - 1);
  localparam logic [5:0]  TX_LAST  = 6'(TX_BITS - 1);
  localparam logic [2:0]  RX_LAST  = 3'(RX_BYTES - 1);

  link_state_e  state_q, state_d;
  logic [39:0]  tx_sh_q, tx_sh_d;
  logic [5:0]   tx_bit_q, tx_bit_d;
  logic [15:0]  cnt_q, cnt_d;         // bit ticks in TX, guard ticks, then timeout
  logic [2:0]   n_q, n_d;
  logic [2:0]   rx_cnt_q, rx_cnt_d;
  logic [7:0]   chk_q, chk_d;
  logic         err_acc_q, err_acc_d;
  logic [15:0]  but_t_q, but_t_d;
  logic [23:0]  an_t_q, an_t_d;
  logic         data_o_q, data_o_d, dir_q, dir_d, busy_q, busy_d;
  logic         error_q, error_d, answer_q, answer_d;
  logic [15:0]  but_q, but_d;
  logic [23:0]  an_q, an_d;

  logic [7:0]   w_addr, w_txchk, w_rx_byte;
  logic [39:0]  w_frame;
  logic         w_rx_en, w_rx_vld, w_rx_fe, w_rx_busy;

  assign w_rx_en = (state_q == ST_WAIT) || (state_q == ST_RX);

  mup_uart_rx #(.BIT_DIV(BIT_DIV)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en_i    (bus.clk_en),
    .en_i        (w_rx_en),
    .rxd_i       (bus.data_i),
    .byte_o      (w_rx_byte),
    .byte_vld_o  (w_rx_vld),
    .frame_err_o (w_rx_fe),
    .busy_o      (w_rx_busy)
  );

  // Whole TX packet as one LSB-first bit stream, start/stop bits included.
  always_comb begin
    w_addr  = {ADDR_TAG, bus.n_mup};
    w_txchk = chk_add(chk_add(w_addr, bus.led[7:0]), bus.led[15:8]);
    w_frame = {1'b1, w_txchk, 1'b0, 1'b1, bus.led[15:8], 1'b0,
               1'b1, bus.led[7:0], 1'b0, 1'b1, w_addr, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      rx_cnt_q  <= '0;
      chk_q     <= '0;
      err_acc_q <= 1'b0;
      but_t_q   <= '0;
      an_t_q    <= '0;
      data_o_q  <= 1'b1;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      answer_q  <= 1'b0;
      but_q     <= '0;
      an_q      <= '0;
    end else if (bus.clk_en) begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      tx_bit_q  <= tx_bit_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      rx_cnt_q  <= rx_cnt_d;
      chk_q     <= chk_d;
      err_acc_q <= err_acc_d;
      but_t_q   <= but_t_d;
      an_t_q    <= an_t_d;
      data_o_q  <= data_o_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      answer_q  <= answer_d;
      but_q     <= but_d;
      an_q      <= an_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    tx_bit_d  = tx_bit_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    rx_cnt_d  = rx_cnt_q;
    chk_d     = chk_q;
    err_acc_d = err_acc_q;
    but_t_d   = but_t_q;
    an_t_d    = an_t_q;
    data_o_d  = data_o_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    error_d   = error_q;
    answer_d  = answer_q;
    but_d     = but_q;
    an_d      = an_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d       = bus.n_mup;
          tx_sh_d   = w_frame;
          data_o_d  = w_frame[0];
          dir_d     = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          tx_bit_d  = '0;
          rx_cnt_d  = '0;
          chk_d     = '0;
          err_acc_d = 1'b0;
          but_t_d   = '0;
          an_t_d    = '0;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        if (cnt_q == BD_M1) begin
          cnt_d = '0;
          if (tx_bit_q == TX_LAST) begin
            data_o_d = 1'b1;
            state_d  = ST_GUARD;
          end else begin
            tx_bit_d = tx_bit_q + 6'd1;
            tx_sh_d  = {1'b1, tx_sh_q[39:1]};
            data_o_d = tx_sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_M1) begin
          cnt_d   = '0;
          dir_d   = 1'b0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (w_rx_busy) begin
          state_d = ST_RX;
        end else if (cnt_q == TO_M1) begin
          err_acc_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RX: begin
        if (w_rx_vld) begin
          // Timeout window restarts from each completed byte.
          cnt_d    = '0;
          rx_cnt_d = rx_cnt_q + 3'd1;
          chk_d    = chk_add(chk_q, w_rx_byte);
          if (w_rx_fe) err_acc_d = 1'b1;
          case (rx_cnt_q)
            3'd0:    if (w_rx_byte != {ADDR_TAG, n_q}) err_acc_d = 1'b1;
            3'd1:    but_t_d[7:0]   = w_rx_byte;
            3'd2:    but_t_d[15:8]  = w_rx_byte;
            3'd3:    an_t_d[7:0]    = w_rx_byte;
            3'd4:    an_t_d[15:8]   = w_rx_byte;
            3'd5:    an_t_d[23:16]  = w_rx_byte;
            default: if (w_rx_byte != chk_q) err_acc_d = 1'b1;
          endcase
          if (rx_cnt_q == RX_LAST) state_d = ST_DONE;
        end else if (!w_rx_busy) begin
          // Only idle-line time counts; a byte in flight pauses the window.
          if (cnt_q == TO_M1) begin
            err_acc_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_DONE: begin
        busy_d   = 1'b0;
        answer_d = (rx_cnt_q != 3'd0);
        error_d  = err_acc_q;
        but_d    = err_acc_q ? 16'd0 : but_t_q;
        an_d     = err_acc_q ? 24'd0 : an_t_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.data_o  = data_o_q;
  assign bus.dir_485 = dir_q;
  assign bus.busy    = busy_q;
  assign bus.error   = error_q;
  assign bus.answer  = answer_q;
  assign bus.but     = but_q;
  assign bus.an_data = an_q;

endmodule
`default_nettype wire
